// File: rtl/slurmboy_gpi_debounce.sv
// Button conditioning for gpi: 2-flop sync, per-button debounce, press pulse, sticky pending flag.
// Latency: gpi/press_evt DEBOUNCE_CYCLES+1 edges after s1 sees a steady level; evt_pending one edge later.
// Backpressure: none; evt_clr clears pending next edge. Auto-repeat via SLURMBOY_GPI_AUTOREPEAT_EN.
module slurmboy_gpi_debounce #(
  parameter int CLK_FREQ             = 25125000,
  parameter int N_BUTTONS            = 6,
  parameter int ACTIVE_LOW           = 1,
  parameter int DEBOUNCE_CYCLES      = CLK_FREQ / 100,
  parameter int REPEAT_DELAY_CYCLES  = CLK_FREQ * 2 / 5,
  parameter int REPEAT_PERIOD_CYCLES = CLK_FREQ / 10
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [N_BUTTONS-1:0] btn_in,
  input  logic [N_BUTTONS-1:0] evt_clr,
  output logic [N_BUTTONS-1:0] gpi,
  output logic [N_BUTTONS-1:0] press_evt,
  output logic [N_BUTTONS-1:0] evt_pending
);

  localparam int                   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]        CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BUTTONS-1:0] POL      = {N_BUTTONS{ACTIVE_LOW != 0}};

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  if (REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY_CYCLES and REPEAT_PERIOD_CYCLES must be positive");
  end

  logic [N_BUTTONS-1:0]         s1;
  logic [N_BUTTONS-1:0]         s2;
  logic [N_BUTTONS-1:0]         stable;
  logic [N_BUTTONS-1:0]         stable_nxt;
  logic [N_BUTTONS-1:0]         press_nxt;
  logic [N_BUTTONS-1:0]         evt_nxt;
  logic [N_BUTTONS-1:0][CW-1:0] cnt;
  logic [N_BUTTONS-1:0][CW-1:0] cnt_nxt;

  // Polarity is folded in before the first flop so everything downstream is 1 = pressed.
  always_ff @(posedge clk) begin
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in ^ POL;
      s2 <= s1;
    end
  end

  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press_nxt = stable_nxt & ~stable;

`ifdef SLURMBOY_GPI_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int            RW          = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

  logic [N_BUTTONS-1:0][RW-1:0] rcnt;
  logic [N_BUTTONS-1:0][RW-1:0] rcnt_nxt;
  logic [N_BUTTONS-1:0]         phase;
  logic [N_BUTTONS-1:0]         phase_nxt;
  logic [N_BUTTONS-1:0]         rep_nxt;

  // phase 0 times the initial delay, phase 1 the repeat period; release wins over a due repeat.
  always_comb begin
    rcnt_nxt  = rcnt;
    phase_nxt = phase;
    rep_nxt   = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (press_nxt[i] || !stable_nxt[i]) begin
        rcnt_nxt[i]  = '0;
        phase_nxt[i] = 1'b0;
      end else if (rcnt[i] == (phase[i] ? PERIOD_LAST : DELAY_LAST)) begin
        rcnt_nxt[i]  = '0;
        phase_nxt[i] = 1'b1;
        rep_nxt[i]   = 1'b1;
      end else begin
        rcnt_nxt[i] = rcnt[i] + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rcnt  <= '0;
      phase <= '0;
    end else begin
      rcnt  <= rcnt_nxt;
      phase <= phase_nxt;
    end
  end

  assign evt_nxt = press_nxt | rep_nxt;
`else
  assign evt_nxt = press_nxt;
`endif

  // Pending is fed from the registered pulse, so a set always lands one edge after press_evt.
  always_ff @(posedge clk) begin
    if (RST) begin
      stable      <= '0;
      cnt         <= '0;
      press_evt   <= '0;
      evt_pending <= '0;
    end else begin
      stable      <= stable_nxt;
      cnt         <= cnt_nxt;
      press_evt   <= evt_nxt;
      evt_pending <= press_evt | (evt_pending & ~evt_clr);
    end
  end

  assign gpi = stable;

endmodule

// File: tb/tb_slurmboy_gpi_debounce.sv
// Directed bench for slurmboy_gpi_debounce: DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, repeat 40/10.
module tb_slurmboy_gpi_debounce;

  logic       clk = 1'b0;
  logic       RST;
  logic [5:0] btn_in;
  logic [5:0] evt_clr;
  logic [5:0] gpi;
  logic [5:0] press_evt;
  logic [5:0] evt_pending;

  int checks   = 0;
  int failures = 0;

  slurmboy_gpi_debounce #(
    .CLK_FREQ            (25125000),
    .N_BUTTONS           (6),
    .ACTIVE_LOW          (1),
    .DEBOUNCE_CYCLES     (8),
    .REPEAT_DELAY_CYCLES (40),
    .REPEAT_PERIOD_CYCLES(10)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .btn_in     (btn_in),
    .evt_clr    (evt_clr),
    .gpi        (gpi),
    .press_evt  (press_evt),
    .evt_pending(evt_pending)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle; inputs driven after this are captured by the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; btn_in = 6'h3f; evt_clr = 6'h00;
    repeat (3) tick();
    checks++;
    if ({gpi, press_evt, evt_pending} !== 18'h0) begin
      failures++;
      $display("FAIL reset_state: gpi=%b press=%b pend=%b expected all 0", gpi, press_evt, evt_pending);
    end
    RST = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if ({gpi, press_evt, evt_pending} !== 18'h0) begin
        failures++;
        $display("FAIL reset_idle e=%0d: gpi=%b press=%b pend=%b expected all 0", e, gpi, press_evt, evt_pending);
      end
    end
  endtask

  task automatic test_press();
    btn_in[0] = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      checks++;
      if (gpi !== ((e >= 9) ? 6'b000001 : 6'b0) || press_evt !== ((e == 9) ? 6'b000001 : 6'b0) ||
          evt_pending !== ((e >= 10) ? 6'b000001 : 6'b0)) begin
        failures++;
        $display("FAIL press0 e=%0d: gpi=%b press=%b pend=%b", e, gpi, press_evt, evt_pending);
      end
    end
    btn_in[0] = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      checks++;
      if (gpi !== ((e < 9) ? 6'b000001 : 6'b0) || press_evt !== 6'b0 || evt_pending !== 6'b000001) begin
        failures++;
        $display("FAIL release0 e=%0d: gpi=%b press=%b pend=%b", e, gpi, press_evt, evt_pending);
      end
    end
    evt_clr[0] = 1'b1;
    tick();
    evt_clr[0] = 1'b0;
    checks++;
    if (evt_pending !== 6'b0) begin
      failures++;
      $display("FAIL clr0: pend=%b expected 000000", evt_pending);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    btn_in[2] = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++;
      if (gpi[2] !== 1'b0 || press_evt !== 6'b0) begin
        failures++;
        $display("FAIL bounce_low e=%0d: gpi=%b press=%b expected 0", e, gpi, press_evt);
      end
    end
    btn_in[2] = 1'b1;
    tick();
    btn_in[2] = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (press_evt[2]) pulses++;
      checks++;
      if (gpi !== ((e >= 9) ? 6'b000100 : 6'b0) || press_evt !== ((e == 9) ? 6'b000100 : 6'b0)) begin
        failures++;
        $display("FAIL bounce_settle e=%0d: gpi=%b press=%b", e, gpi, press_evt);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL bounce_pulses: got %0d expected 1", pulses);
    end
    btn_in[2] = 1'b1;
    repeat (12) tick();
    checks++;
    if (gpi[2] !== 1'b0 || evt_pending[2] !== 1'b1) begin
      failures++;
      $display("FAIL bounce_release: gpi2=%b pend2=%b expected 0/1", gpi[2], evt_pending[2]);
    end
  endtask

  task automatic test_clr_collision();
    btn_in[1] = 1'b0;
    repeat (10) tick();
    btn_in[1] = 1'b1;
    tick();
    checks++;
    if (evt_pending[1] !== 1'b1) begin
      failures++;
      $display("FAIL coll_first_pend: pend1=%b expected 1", evt_pending[1]);
    end
    repeat (11) tick();
    btn_in[1] = 1'b0;
    repeat (10) tick();
    checks++;
    if (press_evt[1] !== 1'b1 || evt_pending[1] !== 1'b1) begin
      failures++;
      $display("FAIL coll_second_press: press1=%b pend1=%b expected 1/1", press_evt[1], evt_pending[1]);
    end
    evt_clr[1] = 1'b1;
    tick();
    evt_clr[1] = 1'b0;
    btn_in[1] = 1'b1;
    checks++;
    if (evt_pending[1] !== 1'b1) begin
      failures++;
      $display("FAIL coll_set_wins: pend1=%b expected 1", evt_pending[1]);
    end
    repeat (3) tick();
    checks++;
    if (evt_pending[1] !== 1'b1) begin
      failures++;
      $display("FAIL coll_sticky: pend1=%b expected 1", evt_pending[1]);
    end
    evt_clr[1] = 1'b1;
    tick();
    evt_clr[1] = 1'b0;
    checks++;
    if (evt_pending[1] !== 1'b0) begin
      failures++;
      $display("FAIL coll_clear_alone: pend1=%b expected 0", evt_pending[1]);
    end
    repeat (12) tick();
  endtask

  task automatic test_reset_mid();
    btn_in[3] = 1'b0;
    repeat (7) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({gpi, press_evt, evt_pending} !== 18'h0) begin
      failures++;
      $display("FAIL midreset_state: gpi=%b press=%b pend=%b expected all 0", gpi, press_evt, evt_pending);
    end
    for (int e = 0; e <= 12; e++) begin
      tick();
      checks++;
      if (gpi !== ((e >= 9) ? 6'b001000 : 6'b0) || press_evt !== ((e == 9) ? 6'b001000 : 6'b0)) begin
        failures++;
        $display("FAIL midreset_redebounce e=%0d: gpi=%b press=%b", e, gpi, press_evt);
      end
    end
    btn_in[3] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    btn_in[0] = 1'b0;
    btn_in[5] = 1'b0;
    for (int e = 0; e <= 11; e++) begin
      tick();
      checks++;
      if (press_evt !== ((e == 9) ? 6'b100001 : 6'b0) || gpi !== ((e >= 9) ? 6'b101000 & 6'b100001 | 6'b100001 & {6{1'b1}} : 6'b0)) begin
        failures++;
        $display("FAIL simultaneous e=%0d: gpi=%b press=%b", e, gpi, press_evt);
      end
    end
    btn_in[0] = 1'b1;
    btn_in[5] = 1'b1;
    repeat (12) tick();
    checks++;
    if (gpi !== 6'b0) begin
      failures++;
      $display("FAIL simultaneous_release: gpi=%b expected 000000", gpi);
    end
  endtask

  task automatic test_autorepeat();
    logic exp_p;
    btn_in[4] = 1'b0;
    repeat (9) tick();
    tick();
    checks++;
    if (press_evt !== 6'b010000 || gpi !== 6'b010000) begin
      failures++;
      $display("FAIL repeat_accept: gpi=%b press=%b expected 010000/010000", gpi, press_evt);
    end
    for (int k = 1; k <= 90; k++) begin
      if (k == 71) btn_in[4] = 1'b1;
      tick();
`ifdef SLURMBOY_GPI_AUTOREPEAT_EN
      exp_p = (k == 40) || (k == 50) || (k == 60) || (k == 70);
`else
      exp_p = 1'b0;
`endif
      checks++;
      if (press_evt[4] !== exp_p || gpi[4] !== (k < 80)) begin
        failures++;
        $display("FAIL repeat_hold k=%0d: gpi4=%b press4=%b expected %b/%b", k, gpi[4], press_evt[4], k < 80, exp_p);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    btn_in = 6'h3f;
    evt_clr = 6'h00;
    test_reset();
    test_press();
    test_bounce();
    test_clr_collision();
    test_reset_mid();
    test_simultaneous();
    test_autorepeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slurmboy_gpi_debounce.md
# slurmboy_gpi_debounce

Conditions the six raw board push-buttons into the `gpi[5:0]` bus consumed by `slurmboy_top`. Each pin goes through a two-flop synchroniser, a per-button debounce counter and a rising-edge detector. The block produces clean levels, one-cycle press pulses and sticky pending flags that the core clears. It sits in the iCE40 top level between the button pads and the core, on the PLL clock.

## Interface
- `CLK_FREQ`, 25125000: system clock in Hz; used only for the defaults below.
- `N_BUTTONS`, 6: number of buttons.
- `ACTIVE_LOW`, 1: 1 means a pressed pin reads 0 (pull-up buttons); the pin is inverted at synchroniser input.
- `DEBOUNCE_CYCLES`, CLK_FREQ/100: stable cycles required before a level is accepted; minimum 2.
- `REPEAT_DELAY_CYCLES`, CLK_FREQ*2/5: hold time before the first auto-repeat. Used only with the macro.
- `REPEAT_PERIOD_CYCLES`, CLK_FREQ/10: interval between subsequent auto-repeats. Used only with the macro.
- `clk`  in  1  system clock.
- `RST`  in  1  reset; synchronous, active-high.
- `btn_in`  in  N_BUTTONS  raw asynchronous button pins.
- `evt_clr`  in  N_BUTTONS  per-bit clear of `evt_pending`, sampled each cycle.
- `gpi`  out  N_BUTTONS  debounced level, 1 = pressed.
- `press_evt`  out  N_BUTTONS  one-cycle pulse per accepted press (and per auto-repeat).
- `evt_pending`  out  N_BUTTONS  sticky press flag.

## Operation
- Polarity: the logical input is `btn_in ^ {N{ACTIVE_LOW}}`.
- Synchroniser: flops `s1` then `s2` per bit. On reset both load logical 0.
- Debounce, per button: state is `stable` (which drives `gpi`) and `cnt`, sized as clog2(DEBOUNCE_CYCLES) bits.
  - If `s2 == stable`, `cnt` is set to 0. Any glitch shorter than the window therefore restarts the count.
  - If `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`, `cnt` increments.
  - If `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`, `stable` takes `s2` and `cnt` is set to 0.
- Press event: `press_evt[i]` is registered high for exactly one cycle on the edge where `stable[i]` goes 0→1. A 1→0 transition produces no event.
- Pending: `evt_pending[i]` is set by `press_evt[i]` and cleared by `evt_clr[i]`. If both occur in the same cycle, set wins. Clearing an already-clear bit has no effect.
- Buttons are fully independent; simultaneous presses on several bits produce simultaneous pulses.
- Reset mid-operation: every flop returns to its reset value the next edge, and any in-flight count is discarded.
  - A button held through reset is re-debounced from zero after `RST` deasserts.
  - It then produces a fresh `press_evt`.

## Timing
- Reset values: `gpi`, `press_evt` and `evt_pending` are all 0; all counters are 0.
- Latency: let edge 0 be the first edge at which `s1` captures a new level that stays steady.
  - `gpi` and `press_evt` change on edge DEBOUNCE_CYCLES+1.
  - `evt_pending` sets on the edge after that.
- Release latency is identical; no pulse is generated on release.
- `evt_clr` takes effect on the next edge (one-cycle latency).
- Counter wrap: `cnt` never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.

## Configuration
- Macro `SLURMBOY_GPI_AUTOREPEAT_EN`.
- Defined: each button has a repeat counter and a phase bit.
  - Both are cleared on press acceptance.
  - While `gpi[i]` is 1, further `press_evt[i]` pulses occur.
  - The first repeat comes exactly REPEAT_DELAY_CYCLES cycles after the initial pulse; later repeats come every REPEAT_PERIOD_CYCLES.
  - Each repeat also sets `evt_pending`.
  - Release (gpi 1→0) clears the repeat state on the same edge, so no pulse is emitted on or after release.
- Undefined: no repeat logic is synthesised and the REPEAT parameters are ignored. Exactly one `press_evt` is produced per press.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, REPEAT_DELAY_CYCLES=40, REPEAT_PERIOD_CYCLES=10.
- Reset with all pins high, then hold 20 cycles -> `gpi`=0, `press_evt`=0, `evt_pending`=0 throughout.
- Drive `btn_in[0]` to 0 at edge 0 and hold -> `gpi[0]`=1 and `press_evt[0]`=1 at edge 9 only; `evt_pending[0]`=1 from edge 10.
- Bounce `btn_in[2]`: low 5 cycles, high 1 cycle, low steady -> no event during the bounce. `gpi[2]` rises 9 edges after the final low sample; exactly one pulse.
- Set `evt_pending[1]`, then assert `evt_clr[1]` on the same cycle as a new `press_evt[1]` -> `evt_pending[1]` stays 1. Assert `evt_clr[1]` alone later -> 0 on the next edge.
- Assert `RST` for 1 cycle while `btn_in[3]` is held low at count 5 -> all outputs 0. A new pulse follows at edge 9 after `RST` deasserts.
- With the macro defined, hold `btn_in[4]` low for 80 cycles after acceptance -> pulses at +0, +40, +50, +60, +70. Releasing then leaves `gpi[4]`=0 after 9 edges and produces no further pulses.
